gfx_wbm_grant_scheduler: RTL

Registered, grant-locking scheduler that shares the single wbm read/write port between the writer and four read masters: clip, fragment processor, blender and textblit. Grant is held from issue until ack_i, so no master switch can occur mid-transfer. Writer has priority, bounded by a starvation limit. The four readers are served round-robin. Data buses stay outside; this block sequences control, address, select and ack routing only.

---
 rtl/gfx_wbm_grant_scheduler.sv | 101 ++++++++++
 1 files changed

// File: rtl/gfx_wbm_grant_scheduler.sv
// gfx_wbm_grant_scheduler: grant-locking writer/4-reader scheduler for the shared wbm port.
// Optional BUSY watchdog enabled by defining GFX_WBM_SCHED_TIMEOUT_EN.
module gfx_wbm_grant_scheduler #(
   parameter int MDW            = 256,
   parameter int STARVE_MAX     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 mw_write_request_i,
   input  logic                 mw_read_request_i,
   input  logic [31:0]          mw_addr_i,
   input  logic [MDW/8-1:0]     mw_sel_i,
   input  logic                 mw_we_i,
   output logic                 mw_ack_o,
   input  logic [3:0]           m_read_request_i,
   input  logic [127:0]         m_addr_i,
   input  logic [4*MDW/8-1:0]   m_sel_i,
   output logic [3:0]           m_ack_o,
   output logic                 read_request_o,
   output logic                 write_request_o,
   output logic [31:0]          addr_o,
   output logic [MDW/8-1:0]     sel_o,
   output logic                 we_o,
   input  logic                 ack_i,
   output logic [4:0]           grant_o,
   output logic                 master_busy_o,
   output logic                 timeout_o
);
   localparam int SW = MDW/8;
   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
   state_t     state, state_n;
   logic [1:0] rr_ptr, rd_idx, g_idx;
   logic [7:0] wr_streak;
   logic [4:0] win;
   logic       wr_req, rd_any, pick_wr, hold, tmo, busy;

   assign wr_req        = mw_write_request_i | mw_read_request_i;
   assign rd_any        = |m_read_request_i;
   assign master_busy_o = wr_req | rd_any;
   assign busy          = state == BUSY;

   // Scan downward so the requester closest to rr_ptr is the one left in rd_idx.
   always_comb begin
      rd_idx = rr_ptr;
      for (int k = 3; k >= 0; k--)
         if (m_read_request_i[rr_ptr + 2'(k)]) rd_idx = rr_ptr + 2'(k);
   end

   assign pick_wr = wr_req & (~rd_any | (wr_streak != 8'(STARVE_MAX)));
   assign win     = pick_wr ? 5'b10000 : rd_any ? (5'd1 << rd_idx) : 5'd0;
   assign g_idx   = grant_o[1] ? 2'd1 : grant_o[2] ? 2'd2 : grant_o[3] ? 2'd3 : 2'd0;
   assign hold    = grant_o[4] ? wr_req : m_read_request_i[g_idx];

`ifdef GFX_WBM_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] t_cnt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) t_cnt <= '0;
      else       t_cnt <= busy ? t_cnt + TW'(1) : '0;
   assign tmo = busy && t_cnt == TW'(TIMEOUT_CYCLES - 1) && !ack_i;
`else
   assign tmo = 1'b0;
`endif
   assign timeout_o = tmo;

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else       state <= state_n;

   always_comb begin
      state_n = state == IDLE ? (master_busy_o ? BUSY : IDLE) :
                state == BUSY ? ((ack_i | ~hold | tmo) ? RELEASE : BUSY) : IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         grant_o   <= '0;
         rr_ptr    <= '0;
         wr_streak <= '0;
      end else if (state == IDLE) begin
         grant_o <= win;
         if (pick_wr)
            wr_streak <= (wr_streak == 8'(STARVE_MAX)) ? wr_streak : wr_streak + 8'd1;
         else begin
            wr_streak <= '0;
            if (rd_any) rr_ptr <= rd_idx + 2'd1;
         end
      end else if (state_n != BUSY)
         grant_o <= '0;

   always_comb begin
      read_request_o  = busy & (grant_o[4] ? mw_read_request_i : 1'b1);
      write_request_o = busy & grant_o[4] & mw_write_request_i;
      we_o            = busy & grant_o[4] & mw_we_i;
      addr_o          = !busy ? '0 : grant_o[4] ? mw_addr_i : m_addr_i[32*g_idx +: 32];
      sel_o           = !busy ? '0 : grant_o[4] ? mw_sel_i : m_sel_i[SW*g_idx +: SW];
      mw_ack_o        = ack_i & busy & grant_o[4];
      m_ack_o         = {4{ack_i & busy}} & grant_o[3:0];
   end
endmodule
